// File: rtl/rv_pkg.sv
// Shared constants and types for the architectural integer register file.
package rv_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

endpackage

// File: rtl/wb_register_file_read_port.sv
// One decode read port: x0 forcing, write-first bypass from writeback, and
// zero output while the array is being cleared.
module rf_read_port
   import rv_pkg::*;
(
   input  logic [AW-1:0]   addr_i,
   input  logic            clearing_i,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   wr_idx_i,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic [XLEN-1:0] mem_data_i,
   output logic [XLEN-1:0] rd_o
);

   // Read selection, priority: x0, bypass, clearing, stored value.
   always_comb begin
      rd_o = {XLEN{1'b0}};
      if (addr_i == REG_ZERO) begin
         rd_o = {XLEN{1'b0}};
      end else if (!clearing_i && wr_en_i && (wr_idx_i == addr_i)) begin
         rd_o = wr_data_i;
      end else if (clearing_i) begin
         rd_o = {XLEN{1'b0}};
      end else begin
         rd_o = mem_data_i;
      end
   end

endmodule

// File: rtl/wb_register_file.sv
// Architectural register file fed by writeback: clear sequencer FSM, storage
// array and two bypassed combinational read ports.
module wb_register_file
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteEnD,
   input  logic [AW-1:0]   RdD,
   input  logic [XLEN-1:0] ResultD,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic            Ready
);

   localparam logic [AW-1:0] FIRST_IDX = 5'd1;
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

   rf_state_t         state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              clr_we_s;
   logic              wb_we_s;
   logic              clearing_s;
   logic [XLEN-1:0]   mem_q [NREG];

   // State and clear-index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RF_CLEAR;
         clr_idx_q <= FIRST_IDX;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Next state and write strobes; the index holds at NREG-1 instead of wrapping.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_we_s  = 1'b0;
      wb_we_s   = 1'b0;
      if (rst) begin
         state_d   = RF_CLEAR;
         clr_idx_d = FIRST_IDX;
      end else begin
         case (state_q)
            RF_CLEAR: begin
               clr_we_s = 1'b1;
               if (clr_idx_q == LAST_IDX) begin
                  state_d   = RF_RUN;
                  clr_idx_d = clr_idx_q;
               end else begin
                  state_d   = RF_CLEAR;
                  clr_idx_d = clr_idx_q + 5'd1;
               end
            end
            RF_RUN: begin
               wb_we_s = RegWriteEnD && (RdD != REG_ZERO);
            end
            default: begin
               state_d   = RF_CLEAR;
               clr_idx_d = FIRST_IDX;
            end
         endcase
      end
   end

   // Storage array: no flop reset, contents come only from the sequencer or writeback.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_q[clr_idx_q] <= {XLEN{1'b0}};
      end else if (wb_we_s) begin
         mem_q[RdD] <= ResultD;
      end
   end

   // The reset cycle behaves like clearing so reads and Ready drop immediately.
   assign clearing_s = rst || (state_q != RF_RUN);
   assign Ready      = !clearing_s;

   rf_read_port u_rd1 (
      .addr_i     (A1),
      .clearing_i (clearing_s),
      .wr_en_i    (RegWriteEnD),
      .wr_idx_i   (RdD),
      .wr_data_i  (ResultD),
      .mem_data_i (mem_q[A1]),
      .rd_o       (RD1)
   );

   rf_read_port u_rd2 (
      .addr_i     (A2),
      .clearing_i (clearing_s),
      .wr_en_i    (RegWriteEnD),
      .wr_idx_i   (RdD),
      .wr_data_i  (ResultD),
      .mem_data_i (mem_q[A2]),
      .rd_o       (RD2)
   );

endmodule
